// File: rtl/pong_pkg.sv
// Shared types and constants for the ping-pong ball engine.
package pong_pkg;

  // Ball engine states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2,
    POINT  = 2'd3
  } state_t;

  // Player identity, used for serve ownership and the winner flag
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam int SCORE_W = 4;

endpackage : pong_pkg

// File: rtl/pong_score_cnt.sv
// Saturating score counter: counts up on inc_i and holds once it reaches max_i.
module pong_score_cnt
  import pong_pkg::*;
(
  input  logic               CLK,
  input  logic               CLRN,
  input  logic               inc_i,
  input  logic [SCORE_W-1:0] max_i,
  output logic [SCORE_W-1:0] count_o
);

  logic [SCORE_W-1:0] count_q;
  logic [SCORE_W-1:0] count_d;

  // Next count: step by one unless already at the ceiling
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q < max_i)) begin
      count_d = count_q + {{(SCORE_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      count_q <= {SCORE_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : pong_score_cnt

// File: rtl/pong_ball_ctrl.sv
// Ping-pong ball engine: moves a one-hot ball across the court on each speed
// tick, judges returns, awards points and tracks serve ownership and the winner.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int WIN_SCORE = 3
) (
  input  logic               CLK,
  input  logic               CLRN,
  input  logic               tick,
  input  logic               serve_L,
  input  logic               serve_R,
  input  logic               hit_L,
  input  logic               hit_R,
  output logic [N_LEDS-1:0]  LED,
  output logic [SCORE_W-1:0] score_L,
  output logic [SCORE_W-1:0] score_R,
  output logic               serve_side,
  output logic               game_over,
  output logic               winner
);

  localparam logic [N_LEDS-1:0]  LED_NONE  = {N_LEDS{1'b0}};
  localparam logic [N_LEDS-1:0]  LED_LEFT  = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [N_LEDS-1:0]  LED_RIGHT = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] WIN_MAX   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [N_LEDS-1:0]  led_q;
  side_t              serve_side_q;
  logic               game_over_q;
  side_t              winner_q;

  logic               point_l_s;
  logic               point_r_s;
  logic               win_l_s;
  logic               win_r_s;
  logic [SCORE_W-1:0] score_l_s;
  logic [SCORE_W-1:0] score_r_s;

  // Point detection: an early swing or a missed ball at the end LED scores for
  // the shooter. A hit at the end LED outranks a simultaneous tick.
  always_comb begin
    point_l_s = 1'b0;
    point_r_s = 1'b0;
    case (state_q)
      MOVE_R: begin
        point_l_s = hit_R ? ~led_q[0] : (tick & led_q[0]);
        point_r_s = 1'b0;
      end
      MOVE_L: begin
        point_l_s = 1'b0;
        point_r_s = hit_L ? ~led_q[N_LEDS-1] : (tick & led_q[N_LEDS-1]);
      end
      default: begin
        point_l_s = 1'b0;
        point_r_s = 1'b0;
      end
    endcase
  end

  // A point is game-winning when the scorer's incremented total hits the target
  assign win_l_s = ((score_l_s + SCORE_ONE) == WIN_MAX);
  assign win_r_s = ((score_r_s + SCORE_ONE) == WIN_MAX);

  // Ball state machine with registered LED, serve ownership and result flags
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q      <= IDLE;
      led_q        <= LED_NONE;
      serve_side_q <= LEFT;
      game_over_q  <= 1'b0;
      winner_q     <= LEFT;
    end else begin
      case (state_q)
        IDLE: begin
          led_q <= LED_NONE;
          if (!game_over_q && (serve_side_q == LEFT) && serve_L) begin
            led_q   <= LED_LEFT;
            state_q <= MOVE_R;
          end else if (!game_over_q && (serve_side_q == RIGHT) && serve_R) begin
            led_q   <= LED_RIGHT;
            state_q <= MOVE_L;
          end else begin
            state_q <= IDLE;
          end
        end
        MOVE_R: begin
          if (point_l_s) begin
            led_q        <= LED_NONE;
            state_q      <= POINT;
            serve_side_q <= RIGHT;
            if (win_l_s) begin
              game_over_q <= 1'b1;
              winner_q    <= LEFT;
            end else begin
              game_over_q <= game_over_q;
            end
          end else if (hit_R) begin
            // Ball sits on the right end: turn it around, it leaves on the next tick
            state_q <= MOVE_L;
          end else if (tick) begin
            led_q <= led_q >> 1;
          end else begin
            state_q <= MOVE_R;
          end
        end
        MOVE_L: begin
          if (point_r_s) begin
            led_q        <= LED_NONE;
            state_q      <= POINT;
            serve_side_q <= LEFT;
            if (win_r_s) begin
              game_over_q <= 1'b1;
              winner_q    <= RIGHT;
            end else begin
              game_over_q <= game_over_q;
            end
          end else if (hit_L) begin
            state_q <= MOVE_R;
          end else if (tick) begin
            led_q <= led_q << 1;
          end else begin
            state_q <= MOVE_L;
          end
        end
        POINT: begin
          led_q <= LED_NONE;
          if (tick) begin
            state_q <= IDLE;
          end else begin
            state_q <= POINT;
          end
        end
        default: begin
          state_q <= IDLE;
          led_q   <= LED_NONE;
        end
      endcase
    end
  end

  pong_score_cnt u_score_l (
    .CLK     (CLK),
    .CLRN    (CLRN),
    .inc_i   (point_l_s),
    .max_i   (WIN_MAX),
    .count_o (score_l_s)
  );

  pong_score_cnt u_score_r (
    .CLK     (CLK),
    .CLRN    (CLRN),
    .inc_i   (point_r_s),
    .max_i   (WIN_MAX),
    .count_o (score_r_s)
  );

  assign LED        = led_q;
  assign score_L    = score_l_s;
  assign score_R    = score_r_s;
  assign serve_side = serve_side_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule : pong_ball_ctrl
